// File: rtl/result_viewer_pkg.sv
// Shared definitions for the result viewer.
//   state_e : top-level FSM encoding (idle, collecting results, displaying results)
//   clog2   : ceil(log2(value)), never less than 1, for sizing counters and indices
package result_viewer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDisplay = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((longint'(1) << width) < longint'(value)) begin
      width++;
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/result_viewer_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability counter.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   raw   : raw asynchronous button input
//   level : debounced button level
module button_debounce
  import result_viewer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync0_q;
  logic            sync1_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  // cnt_q counts consecutive synchronised samples that differ from the current level;
  // a sample equal to the level means the input moved back, so the count restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
      if (sync1_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        level_q <= sync1_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/result_viewer.sv
// Collects N*N signed results from a systolic array, then shows one at a time on LEDs.
//   clk, rst                  : clock, asynchronous active-low reset
//   startSignal               : level request; a rising edge starts a collection run
//   res_valid/res_data/res_ready : result stream handshake (row-major order)
//   result_toggle, dir        : raw step button and step direction (0 forward, 1 backward)
//   sat_mode                  : 1 saturates to LED_W bits, 0 truncates
//   led                       : registered display value, 0 outside display
//   process_done              : all N*N results captured
module result_viewer
  import result_viewer_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startSignal,
  input  logic             res_valid,
  input  logic [ACC_W-1:0] res_data,
  output logic             res_ready,
  input  logic             result_toggle,
  input  logic             dir,
  input  logic             sat_mode,
  output logic [LED_W-1:0] led,
  output logic             process_done
);

  localparam int unsigned Depth = N * N;
  localparam int unsigned IdxW  = clog2(Depth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]  rd_idx_q, rd_idx_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             start_q, start_prev_q, start_edge;
  logic             btn_level, btn_prev_q, press;
  logic             handshake;
  logic [ACC_W-1:0] mem_q [Depth];

  button_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (result_toggle),
    .level(btn_level)
  );

  function automatic logic [LED_W-1:0] to_led(input logic [ACC_W-1:0] value, input logic sat);
    logic [ACC_W-LED_W:0] upper;
    upper = value[ACC_W-1:LED_W-1];
    // In range when every bit above the LED sign bit matches it.
    if (!sat || (upper == '0) || (upper == '1)) begin
      return value[LED_W-1:0];
    end else if (value[ACC_W-1]) begin
      return {1'b1, {(LED_W-1){1'b0}}};
    end else begin
      return {1'b0, {(LED_W-1){1'b1}}};
    end
  endfunction

  assign res_ready    = (state_q == StCollect);
  assign process_done = (state_q == StDisplay);
  assign handshake    = res_valid && res_ready;
  assign start_edge   = start_q && !start_prev_q;
  assign press        = btn_level && !btn_prev_q;
  assign led          = led_q;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d  = StCollect;
          wr_idx_d = '0;
        end
      end
      StCollect: begin
        if (handshake) begin
          if (wr_idx_q == LastIdx) begin
            state_d  = StDisplay;
            rd_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StDisplay: begin
        if (start_edge) begin
          state_d  = StCollect;
          wr_idx_d = '0;
        end else if (press) begin
          if (dir) begin
            rd_idx_d = (rd_idx_q == '0) ? LastIdx : rd_idx_q - 1'b1;
          end else begin
            rd_idx_d = (rd_idx_q == LastIdx) ? '0 : rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // led trails rd_idx/sat_mode by one cycle and drops to 0 as soon as display is left.
  always_comb begin
    led_d = '0;
    if ((state_q == StDisplay) && (state_d == StDisplay)) begin
      led_d = to_led(mem_q[rd_idx_q], sat_mode);
    end
  end

  // Start flops reset high so a level already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      led_q        <= '0;
      start_q      <= 1'b1;
      start_prev_q <= 1'b1;
      btn_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      led_q        <= led_d;
      start_q      <= startSignal;
      start_prev_q <= start_q;
      btn_prev_q   <= btn_level;
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      mem_q[wr_idx_q] <= res_data;
    end
  end

endmodule

// File: doc/result_viewer.md
RESULT_VIEWER -- requirements
Module: result_viewer

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension; the buffer holds N*N results.
REQ-002 SHALL have parameter ACC_W, default 32, meaning accumulator result width (signed).
REQ-003 SHALL have parameter LED_W, default 8, meaning LED display width (signed), LED_W <= ACC_W.
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 1_000_000, meaning stable-cycle count for the button (20 ms at 50 MHz).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port startSignal  input  1  meaning level request to begin a collection run.
REQ-008 SHALL have port res_valid  input  1  meaning the array presents a result word.
REQ-009 SHALL have port res_data  input  ACC_W  meaning the signed result word, row-major order.
REQ-010 SHALL have port res_ready  output  1  meaning the block accepts a result this cycle.
REQ-011 SHALL have port result_toggle  input  1  meaning raw asynchronous push-button that steps the display.
REQ-012 SHALL have port dir  input  1  meaning step direction: 0 forward, 1 backward.
REQ-013 SHALL have port sat_mode  input  1  meaning 1 saturates to LED_W, 0 truncates to the low LED_W bits.
REQ-014 SHALL have port led  output  LED_W  meaning the registered signed value of the selected result.
REQ-015 SHALL have port process_done  output  1  meaning all N*N results are captured.

Function
REQ-016 SHALL implement an FSM with states IDLE, COLLECT and DISPLAY.
REQ-017 SHALL move from IDLE to COLLECT on a 0->1 edge of registered startSignal; a level held high from reset SHALL NOT start a run.
REQ-018 SHALL drive res_ready=1 only in COLLECT; a handshake is res_valid&&res_ready, and it writes res_data to buffer[wr_idx] and increments wr_idx.
REQ-019 SHALL ignore res_valid outside COLLECT, with no buffer write.
REQ-020 SHALL, on the handshake at wr_idx=N*N-1, go to DISPLAY next cycle with process_done=1, rd_idx=0 and res_ready=0.
REQ-021 SHALL, in DISPLAY, treat a debounced press (0->1 of the debounced level) as a step: rd_idx+1 mod N*N when dir=0, rd_idx-1 mod N*N when dir=1 (0 wraps to N*N-1, N*N-1 wraps to 0).
REQ-022 SHALL ignore presses in IDLE and COLLECT.
REQ-023 SHALL let a new startSignal rising edge in DISPLAY clear process_done, zero wr_idx and return to COLLECT; buffer contents are overwritten, not cleared.
REQ-024 SHALL, in sat_mode=1, clamp led to [-2^(LED_W-1), 2^(LED_W-1)-1]; in sat_mode=0, led is res[LED_W-1:0].
REQ-025 SHALL register led one cycle after rd_idx or sat_mode changes, and hold led=0 outside DISPLAY.
REQ-026 SHALL pass result_toggle through a 2-flop synchroniser, then update the debounced level only after DEBOUNCE_CYC consecutive identical synchronised samples; any change restarts the count.
REQ-027 SHALL size the debounce counter as clog2(DEBOUNCE_CYC+1) bits and the indices as clog2(N*N) bits (minimum 1).

Reset
REQ-028 SHALL, on rst low and asynchronously, force: state=IDLE, led=0, process_done=0, res_ready=0, wr_idx=0, rd_idx=0, debounced level=0, debounce count=0, synchroniser flops=0.
REQ-029 SHALL, on reset mid-COLLECT, discard the partial run; after release a fresh start edge requires N*N new writes.
REQ-030 SHALL NOT require the buffer contents to be reset.

Structure
REQ-031 SHALL place the FSM state encodings and the clog2 helper function in the shared package/include file.
REQ-032 SHALL implement the debounce logic (synchroniser plus counter, output debounced level) as the sub-module button_debounce, parameterised by DEBOUNCE_CYC.
REQ-033 SHALL infer the result buffer as a register array of N*N x ACC_W.

Verification
All scenarios use N=2, ACC_W=16, LED_W=8, DEBOUNCE_CYC=4.
REQ-034 Scenario 1: hold rst low with startSignal=1 -> led=0, process_done=0, res_ready=0; after release with startSignal held high, no run starts.
REQ-035 Scenario 2: start edge, then write 5, -3, 300, -200 with gaps in res_valid -> process_done rises the cycle after the 4th handshake; led=5 one cycle later; a 5th res_valid is ignored.
REQ-036 Scenario 3: sat_mode=1, dir=0, four clean presses -> led sequence -3, 127, -128, 5 (wrap).
REQ-037 Scenario 4: at rd_idx=2, switch sat_mode to 0 -> led=44 (0x2C); 2-cycle glitch on result_toggle -> no step.
REQ-038 Scenario 5: at rd_idx=0, dir=1, one press -> rd_idx=3, led=56 (0xFF38 truncated) with sat_mode=0.
REQ-039 Scenario 6: assert rst after 2 of 4 writes -> all outputs 0, state IDLE; new start plus 4 writes -> process_done only after the 4th.
